// File: rtl/sync_tx_pkg.sv
// Shared definitions for the serial sync-frame transmitter: state encoding,
// default sync preamble and small elaboration-time helpers.
package sync_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_PAR,
        ST_GAP
    } tx_state_t;

    localparam logic [7:0] SYNC_PREAMBLE = 8'hAA;
    localparam int         SYNC_PRE_W    = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load shift register presenting its MSB; shifts toward the MSB so the
// word leaves MSB first.
module piso_shift #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg <= RST_VAL;
        end else if (load) begin
            sr_reg <= din;
        end else if (shift) begin
            sr_reg <= sr_reg << 1;
        end
    end

    assign msb = sr_reg[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: preamble, payload MSB first, optional even parity,
// then an idle gap. One bit per clk on a registered dout.
module sync_frame_tx
    import sync_tx_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               PRE_W     = SYNC_PRE_W,
    parameter logic [PRE_W-1:0] PREAMBLE  = PRE_W'(SYNC_PREAMBLE),
    parameter int               PARITY_EN = 0,
    parameter int               GAP_BITS  = 2,
    parameter logic             IDLE_BIT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done
);

    localparam int               CNT_W     = cnt_width(max3(PRE_W, DATA_W, GAP_BITS));
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    tx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dout_reg, dout_next;
    logic             done_reg, done_next;
    logic             par_reg, par_next;
    logic             pre_load, pre_shift, pre_msb;
    logic             data_load, data_shift, data_msb;
    logic             frame_end;

    // Both shifters present the next bit still to be sent, so dout can be
    // registered one cycle ahead of the state that owns that bit.
    piso_shift #(.W(PRE_W), .RST_VAL(PREAMBLE)) u_pre_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (pre_load),
        .shift (pre_shift),
        .din   (PREAMBLE),
        .msb   (pre_msb)
    );

    piso_shift #(.W(DATA_W), .RST_VAL('0)) u_data_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (data_load),
        .shift (data_shift),
        .din   (tx_data),
        .msb   (data_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            dout_reg  <= IDLE_BIT;
            done_reg  <= 1'b0;
            par_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            par_reg   <= par_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dout_next  = IDLE_BIT;
        done_next  = 1'b0;
        par_next   = par_reg;
        pre_load   = 1'b0;
        pre_shift  = 1'b0;
        data_load  = 1'b0;
        data_shift = 1'b0;
        frame_end  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (tx_valid) begin
                    data_load  = 1'b1;
                    par_next   = ^tx_data;
                    pre_shift  = 1'b1;
                    dout_next  = pre_msb;
                    cnt_next   = '0;
                    state_next = ST_PRE;
                end
            end
            ST_PRE: begin
                if (cnt_reg == PRE_LAST) begin
                    // Preamble shifter is restored here so it is ready for the next frame.
                    pre_load   = 1'b1;
                    data_shift = 1'b1;
                    dout_next  = data_msb;
                    cnt_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    pre_shift  = 1'b1;
                    dout_next  = pre_msb;
                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_reg == DATA_LAST) begin
                    if (PARITY_EN != 0) begin
                        dout_next  = par_reg;
                        state_next = ST_PAR;
                    end else begin
                        frame_end = 1'b1;
                    end
                end else begin
                    data_shift = 1'b1;
                    dout_next  = data_msb;
                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            ST_PAR: begin
                frame_end = 1'b1;
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (frame_end) begin
            done_next  = 1'b1;
            dout_next  = IDLE_BIT;
            cnt_next   = '0;
            state_next = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
        end
    end

    assign tx_ready   = (state_reg == ST_IDLE) && !rst;
    assign busy       = (state_reg != ST_IDLE);
    assign dout       = dout_reg;
    assign frame_done = done_reg;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Randomized bench for sync_frame_tx: two instances (default, and parity with no
// gap) share stimulus and are checked each cycle against a frame-position model.
module tb_sync_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    wire  [1:0] ready_o;
    wire  [1:0] dout_o;
    wire  [1:0] busy_o;
    wire  [1:0] done_o;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] PRE_PAT = 8'hAA;

    int         par_en[2];
    int         gap_n[2];
    int         pos[2];
    logic [7:0] word[2];
    logic       fd_exp[2];

    sync_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (ready_o[0]),
        .dout       (dout_o[0]),
        .busy       (busy_o[0]),
        .frame_done (done_o[0])
    );

    sync_frame_tx #(.PARITY_EN(1), .GAP_BITS(0)) dut_p (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (ready_o[1]),
        .dout       (dout_o[1]),
        .busy       (busy_o[1]),
        .frame_done (done_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Line level at 1-based position p of a frame carrying w.
    function automatic logic frame_bit(input int p, input logic [7:0] w, input int par);
        logic [7:0] pat;
        pat = PRE_PAT;
        if (p >= 1 && p <= 8)  return pat[8 - p];
        if (p >= 9 && p <= 16) return w[16 - p];
        if (par != 0 && p == 17) return ^w;
        return 1'b1;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int len;
            len = 16 + par_en[i] + gap_n[i];
            if (rst) begin
                pos[i]    = 0;
                fd_exp[i] = 1'b0;
            end else begin
                fd_exp[i] = (pos[i] == 16 + par_en[i]);
                if (pos[i] == 0) begin
                    if (tx_valid) begin
                        pos[i]  = 1;
                        word[i] = tx_data;
                    end
                end else if (pos[i] == len) begin
                    pos[i] = 0;
                end else begin
                    pos[i]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic exp_d;
            exp_d = (pos[i] == 0) ? 1'b1 : frame_bit(pos[i], word[i], par_en[i]);
            check_eq($sformatf("dout%0d", i), 32'(dout_o[i]), 32'(exp_d));
            check_eq($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(pos[i] != 0));
            check_eq($sformatf("ready%0d", i), 32'(ready_o[i]), 32'(pos[i] == 0 && !rst));
            check_eq($sformatf("frame_done%0d", i), 32'(done_o[i]), 32'(fd_exp[i]));
        end
        $display("t=%0t rst=%0b v=%0b d=%02h | dout=%b%b busy=%b%b rdy=%b%b done=%b%b",
                 $time, rst, tx_valid, tx_data, dout_o[0], dout_o[1], busy_o[0], busy_o[1],
                 ready_o[0], ready_o[1], done_o[0], done_o[1]);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        tx_valid = v;
        tx_data  = d;
        rst      = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset asserted mid-cycle must take effect before the next edge.
    task automatic async_rst_pulse();
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("arst_dout%0d", i), 32'(dout_o[i]), 32'd1);
            check_eq($sformatf("arst_busy%0d", i), 32'(busy_o[i]), 32'd0);
            check_eq($sformatf("arst_ready%0d", i), 32'(ready_o[i]), 32'd0);
            check_eq($sformatf("arst_done%0d", i), 32'(done_o[i]), 32'd0);
        end
        step(1'b1, 8'($urandom), 1'b1);
        step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        par_en[0] = 0; gap_n[0] = 2;
        par_en[1] = 1; gap_n[1] = 0;
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; word[i] = 8'h00; fd_exp[i] = 1'b0;
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("rst_dout%0d", i), 32'(dout_o[i]), 32'd1);
            check_eq($sformatf("rst_busy%0d", i), 32'(busy_o[i]), 32'd0);
            check_eq($sformatf("rst_ready%0d", i), 32'(ready_o[i]), 32'd0);
            check_eq($sformatf("rst_done%0d", i), 32'(done_o[i]), 32'd0);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Single frames: 5A, then AA (payload extends the preamble pattern).
        step(1'b1, 8'h5A, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 8'($urandom), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 8'($urandom), 1'b0);

        // Parity cases (07 -> 1, 03 -> 0) on the parity instance.
        step(1'b1, 8'h07, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 8'h00, 1'b0);

        // Valid held high: back-to-back frames, later data ignored while busy.
        step(1'b1, 8'h01, 1'b0);
        for (int c = 0; c < 40; c++) step(1'b1, 8'h02, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 8'h00, 1'b0);

        // Reset during payload bit 3.
        step(1'b1, 8'hC3, 1'b0);
        for (int c = 0; c < 11; c++) step(1'b0, 8'h00, 1'b0);
        async_rst_pulse();
        for (int c = 0; c < 20; c++) step(1'b0, 8'h00, 1'b0);

        // Random traffic with data/valid churn while busy and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_rst_pulse();
            end else begin
                step($urandom_range(0, 3) != 0, 8'($urandom), 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
